axi_lite_write_requester: RTL and testbench

AXI_LITE_WRITE_REQUESTER -- requirements
Module: axi_lite_write_requester

---
 rtl/axi_lite_write_requester_if.sv | 51 +++++
 rtl/axi_lite_write_requester.sv | 154 +++++++++++++++
 tb/tb_axi_lite_write_requester.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_write_requester_if.sv
// Command, AW, W and B channels of the AXI4-Lite write requester, grouped as one bundle.
// master: the requester. slave: the command source and AXI4-Lite slave, as seen by a bench.
interface axi_lite_write_requester_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);
  localparam int STROBE_SIZE = DATA_SIZE / 8;

  // Handshake rule on every channel: a transfer happens on a rising aclk edge where
  // valid and ready are both high; a raised valid keeps its payload stable until then.
  logic [ADDRESS_SIZE-1:0] cmd_address;
  logic [DATA_SIZE-1:0]    cmd_data;
  logic [STROBE_SIZE-1:0]  cmd_strobe;
  logic                    cmd_valid;
  logic                    cmd_ready;

  logic [ADDRESS_SIZE-1:0] write_address;
  logic                    write_address_valid;
  logic                    write_address_ready;

  logic [DATA_SIZE-1:0]    write_data;
  logic [STROBE_SIZE-1:0]  write_data_strobe;
  logic                    write_data_valid;
  logic                    write_data_ready;

  logic [1:0]              write_response;
  logic                    write_response_valid;
  logic                    write_response_ready;

  modport master (
    input  cmd_address, cmd_data, cmd_strobe, cmd_valid,
    output cmd_ready,
    output write_address, write_address_valid,
    input  write_address_ready,
    output write_data, write_data_strobe, write_data_valid,
    input  write_data_ready,
    input  write_response, write_response_valid,
    output write_response_ready
  );

  modport slave (
    output cmd_address, cmd_data, cmd_strobe, cmd_valid,
    input  cmd_ready,
    input  write_address, write_address_valid,
    output write_address_ready,
    input  write_data, write_data_strobe, write_data_valid,
    output write_data_ready,
    output write_response, write_response_valid,
    input  write_response_ready
  );
endinterface

// File: rtl/axi_lite_write_requester.sv
// Single-outstanding AXI4-Lite write requester: one command becomes one AW+W pair and
// one B response, reported as a status pulse, with a sticky response-wait timeout flag.
module axi_lite_write_requester #(
  parameter int ADDRESS_SIZE   = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  axi_lite_write_requester_if.master bus,
  output logic [1:0]  status_response,
  output logic        status_valid,
  output logic        status_timeout,
  output logic [15:0] error_count,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int STROBE_SIZE = DATA_SIZE / 8;
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ARM  = COUNT_WIDTH'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDRESS_SIZE-1:0] write_address_q, write_address_d;
  logic                    write_address_valid_q, write_address_valid_d;
  logic [DATA_SIZE-1:0]    write_data_q, write_data_d;
  logic [STROBE_SIZE-1:0]  write_data_strobe_q, write_data_strobe_d;
  logic                    write_data_valid_q, write_data_valid_d;
  logic [1:0]              status_response_q, status_response_d;
  logic                    status_valid_q, status_valid_d;
  logic                    status_timeout_q, status_timeout_d;
  logic [15:0]             error_count_q, error_count_d;
  logic [COUNT_WIDTH-1:0]  timeout_count_q, timeout_count_d;

  logic cmd_fire, aw_fire, w_fire, resp_fire;
  logic aw_settled, w_settled;

  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign aw_fire   = write_address_valid_q && bus.write_address_ready;
  assign w_fire    = write_data_valid_q && bus.write_data_ready;
  assign resp_fire = bus.write_response_valid && bus.write_response_ready;

  // A channel is settled once it has completed earlier or completes on this edge.
  assign aw_settled = !write_address_valid_q || bus.write_address_ready;
  assign w_settled  = !write_data_valid_q || bus.write_data_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_fire) state_d = ISSUE;
      ISSUE:     if (aw_settled && w_settled) state_d = WAIT_RESP;
      WAIT_RESP: if (resp_fire) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready            = aresetn && (state_q == IDLE);
    bus.write_response_ready = (state_q == WAIT_RESP);
    busy                     = (state_q != IDLE);
    state_dbg                = state_q;
  end

  always_comb begin
    write_address_d       = write_address_q;
    write_address_valid_d = write_address_valid_q;
    write_data_d          = write_data_q;
    write_data_strobe_d   = write_data_strobe_q;
    write_data_valid_d    = write_data_valid_q;
    status_response_d     = status_response_q;
    status_valid_d        = 1'b0;
    status_timeout_d      = status_timeout_q;
    error_count_d         = error_count_q;
    timeout_count_d       = timeout_count_q;

    if (cmd_fire) begin
      write_address_d       = bus.cmd_address;
      write_data_d          = bus.cmd_data;
      write_data_strobe_d   = bus.cmd_strobe;
      write_address_valid_d = 1'b1;
      write_data_valid_d    = 1'b1;
      status_timeout_d      = 1'b0;
      timeout_count_d       = '0;
    end else if (state_q != IDLE) begin
      // Flag is armed one count early so it is visible as the count reaches its last value.
      if (timeout_count_q != COUNT_LAST) timeout_count_d = timeout_count_q + 1'b1;
      if (timeout_count_q == COUNT_ARM) status_timeout_d = 1'b1;
    end

    if (aw_fire) write_address_valid_d = 1'b0;
    if (w_fire)  write_data_valid_d    = 1'b0;

    if (resp_fire) begin
      status_response_d = bus.write_response;
      status_valid_d    = 1'b1;
      if (bus.write_response != 2'b00 && error_count_q != 16'hFFFF) begin
        error_count_d = error_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      write_address_q       <= '0;
      write_address_valid_q <= 1'b0;
      write_data_q          <= '0;
      write_data_strobe_q   <= '0;
      write_data_valid_q    <= 1'b0;
      status_response_q     <= 2'b00;
      status_valid_q        <= 1'b0;
      status_timeout_q      <= 1'b0;
      error_count_q         <= 16'd0;
      timeout_count_q       <= '0;
    end else begin
      write_address_q       <= write_address_d;
      write_address_valid_q <= write_address_valid_d;
      write_data_q          <= write_data_d;
      write_data_strobe_q   <= write_data_strobe_d;
      write_data_valid_q    <= write_data_valid_d;
      status_response_q     <= status_response_d;
      status_valid_q        <= status_valid_d;
      status_timeout_q      <= status_timeout_d;
      error_count_q         <= error_count_d;
      timeout_count_q       <= timeout_count_d;
    end
  end

  assign bus.write_address       = write_address_q;
  assign bus.write_address_valid = write_address_valid_q;
  assign bus.write_data          = write_data_q;
  assign bus.write_data_strobe   = write_data_strobe_q;
  assign bus.write_data_valid    = write_data_valid_q;
  assign status_response         = status_response_q;
  assign status_valid            = status_valid_q;
  assign status_timeout          = status_timeout_q;
  assign error_count             = error_count_q;

endmodule

// File: tb/tb_axi_lite_write_requester.sv
// Directed bench for axi_lite_write_requester: a vector table of single writes with
// per-channel slave delays, plus hand sequences for throughput, timeout, reset and saturation.
module tb_axi_lite_write_requester;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_write_requester_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

  logic [1:0]  status_response;
  logic        status_valid;
  logic        status_timeout;
  logic [15:0] error_count;
  logic        busy;
  logic [1:0]  state_dbg;

  axi_lite_write_requester #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .status_response(status_response), .status_valid(status_valid),
    .status_timeout(status_timeout), .error_count(error_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  resp;
    logic [15:0] exp_err;
    logic        exp_to;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];   // {status_response, error_count} expected at each status pulse

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every status pulse must match the next expected entry.
  always @(negedge aclk) begin
    logic [17:0] e;
    if (status_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_status: got resp=%0h err=%0h expected no pulse",
                 status_response, error_count);
      end else begin
        e = exp_q.pop_front();
        chk("status_resp_err", 64'({status_response, error_count}), 64'(e));
      end
    end
  end

  task automatic idle_bus();
    bus.cmd_valid = 1'b0;
    bus.cmd_address = '0;
    bus.cmd_data = '0;
    bus.cmd_strobe = '0;
    bus.write_address_ready = 1'b0;
    bus.write_data_ready = 1'b0;
    bus.write_response_valid = 1'b0;
    bus.write_response = 2'b00;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cmd_address = a;
    bus.cmd_data = d;
    bus.cmd_strobe = s;
    bus.cmd_valid = 1'b1;
  endtask

  // One full write; called at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    logic aw_pend, w_pend;
    int i;
    chk({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    chk({tag, " state_idle"}, 64'(state_dbg), 64'(0));
    drive_cmd(v.addr, v.data, v.strb);
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    chk({tag, " timeout_cleared"}, 64'(status_timeout), 64'(0));
    aw_pend = 1'b1;
    w_pend = 1'b1;
    i = 0;
    while ((aw_pend || w_pend) && i < 40) begin
      chk($sformatf("%s state_issue c%0d", tag, i), 64'(state_dbg), 64'(1));
      chk($sformatf("%s aw_valid c%0d", tag, i), 64'(bus.write_address_valid), 64'(aw_pend));
      chk($sformatf("%s w_valid c%0d", tag, i), 64'(bus.write_data_valid), 64'(w_pend));
      chk($sformatf("%s b_ready c%0d", tag, i), 64'(bus.write_response_ready), 64'(0));
      chk($sformatf("%s cmd_ready c%0d", tag, i), 64'(bus.cmd_ready), 64'(0));
      if (aw_pend) chk($sformatf("%s aw_addr c%0d", tag, i), 64'(bus.write_address), 64'(v.addr));
      if (w_pend) begin
        chk($sformatf("%s w_data c%0d", tag, i), 64'(bus.write_data), 64'(v.data));
        chk($sformatf("%s w_strb c%0d", tag, i), 64'(bus.write_data_strobe), 64'(v.strb));
      end
      bus.write_address_ready = aw_pend && (i >= v.aw_dly);
      bus.write_data_ready = w_pend && (i >= v.w_dly);
      @(negedge aclk);
      if (bus.write_address_ready) aw_pend = 1'b0;
      if (bus.write_data_ready) w_pend = 1'b0;
      bus.write_address_ready = 1'b0;
      bus.write_data_ready = 1'b0;
      i++;
    end
    chk({tag, " issue_bound"}, 64'({aw_pend, w_pend}), 64'(0));
    for (int j = 0; j <= v.b_dly; j++) begin
      chk($sformatf("%s state_wait w%0d", tag, j), 64'(state_dbg), 64'(2));
      chk($sformatf("%s b_ready w%0d", tag, j), 64'(bus.write_response_ready), 64'(1));
      chk($sformatf("%s valids_low w%0d", tag, j),
          64'({bus.write_address_valid, bus.write_data_valid}), 64'(0));
      if (j == v.b_dly) begin
        bus.write_response_valid = 1'b1;
        bus.write_response = v.resp;
        exp_q.push_back({v.resp, v.exp_err});
      end
      @(negedge aclk);
    end
    bus.write_response_valid = 1'b0;
    bus.write_response = 2'b00;
    chk({tag, " status_valid"}, 64'(status_valid), 64'(1));
    chk({tag, " status_timeout"}, 64'(status_timeout), 64'(v.exp_to));
    chk({tag, " cmd_ready_back"}, 64'(bus.cmd_ready), 64'(1));
    chk({tag, " busy_low"}, 64'(busy), 64'(0));
    @(negedge aclk);
    chk({tag, " status_pulse_end"}, 64'(status_valid), 64'(0));
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Hand-computed: response accepted k = max(aw_dly, w_dly) + 1 + b_dly cycles after
    // ISSUE entry; with TIMEOUT_CYCLES = 8 the flag shows at the status pulse iff k >= 6.
    vecs[0] = '{32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 16'd0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h1234_5678, 4'h3, 3, 0, 0, 2'b00, 16'd0, 1'b0};
    vecs[2] = '{32'h0000_0004, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b10, 16'd1, 1'b0};
    vecs[3] = '{32'h0000_0008, 32'hA5A5_A5A5, 4'h5, 0, 2, 1, 2'b11, 16'd2, 1'b0};
    vecs[4] = '{32'h0000_000C, 32'h0000_0000, 4'h0, 1, 1, 0, 2'b01, 16'd3, 1'b0};
    vecs[5] = '{32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 2, 1, 3, 2'b00, 16'd3, 1'b1};
    vecs[6] = '{32'h0000_0014, 32'h1122_3344, 4'h8, 0, 4, 0, 2'b00, 16'd3, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h0F0F_0F0F, 4'hC, 0, 0, 2, 2'b00, 16'd3, 1'b0};

    idle_bus();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst cmd_ready", 64'(bus.cmd_ready), 64'(0));
    chk("rst valids", 64'({bus.write_address_valid, bus.write_data_valid, status_valid}), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst b_ready", 64'(bus.write_response_ready), 64'(0));
    chk("rst payload", 64'({bus.write_address, bus.write_data}), 64'(0));
    chk("rst strobe", 64'(bus.write_data_strobe), 64'(0));
    chk("rst status", 64'({status_response, status_timeout, error_count}), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst cmd_ready", 64'(bus.cmd_ready), 64'(1));

    for (int n = 0; n < 8; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Zero-wait slave, command held: IDLE, ISSUE, WAIT_RESP, IDLE, with the next accept
    // coinciding with the status pulse; B valid held in IDLE/ISSUE must be ignored.
    bus.write_address_ready = 1'b1;
    bus.write_data_ready = 1'b1;
    bus.write_response_valid = 1'b1;
    bus.write_response = 2'b00;
    exp_q.push_back({2'b00, 16'd3});
    exp_q.push_back({2'b00, 16'd3});
    drive_cmd(32'h0000_0100, 32'h0101_0101, 4'hF);
    chk("tput t0 state", 64'(state_dbg), 64'(0));
    @(negedge aclk);
    chk("tput t1 state", 64'(state_dbg), 64'(1));
    chk("tput t1 addr", 64'(bus.write_address), 64'(32'h0000_0100));
    drive_cmd(32'h0000_0200, 32'h0202_0202, 4'hF);
    @(negedge aclk);
    chk("tput t2 state", 64'(state_dbg), 64'(2));
    @(negedge aclk);
    chk("tput t3 state", 64'(state_dbg), 64'(0));
    chk("tput t3 status_valid", 64'(status_valid), 64'(1));
    chk("tput t3 cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    chk("tput t4 state", 64'(state_dbg), 64'(1));
    chk("tput t4 addr", 64'(bus.write_address), 64'(32'h0000_0200));
    chk("tput t4 data", 64'(bus.write_data), 64'(32'h0202_0202));
    repeat (2) @(negedge aclk);
    chk("tput t6 status_valid", 64'(status_valid), 64'(1));
    idle_bus();
    @(negedge aclk);

    // Slave never answers: flag rises 7 cycles after ISSUE entry, transaction still pending.
    bus.write_address_ready = 1'b1;
    bus.write_data_ready = 1'b1;
    drive_cmd(32'h0000_0020, 32'h0000_0020, 4'hF);
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("to c%0d timeout", i), 64'(status_timeout), 64'(i >= 7));
      chk($sformatf("to c%0d busy", i), 64'(busy), 64'(1));
      chk($sformatf("to c%0d cmd_ready", i), 64'(bus.cmd_ready), 64'(0));
      @(negedge aclk);
      bus.write_address_ready = 1'b0;
      bus.write_data_ready = 1'b0;
    end
    bus.write_response_valid = 1'b1;
    exp_q.push_back({2'b00, 16'd3});
    @(negedge aclk);
    bus.write_response_valid = 1'b0;
    chk("to late status_valid", 64'(status_valid), 64'(1));
    chk("to late sticky", 64'(status_timeout), 64'(1));
    chk("to late busy", 64'(busy), 64'(0));
    @(negedge aclk);
    chk("to sticky idle", 64'(status_timeout), 64'(1));

    // One-cycle reset while waiting for a DECERR response that must never be accepted.
    bus.write_address_ready = 1'b1;
    bus.write_data_ready = 1'b1;
    drive_cmd(32'h0000_0030, 32'h3030_3030, 4'hF);
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    @(negedge aclk);
    bus.write_address_ready = 1'b0;
    bus.write_data_ready = 1'b0;
    chk("mrst in_wait", 64'(state_dbg), 64'(2));
    aresetn = 1'b0;
    bus.write_response_valid = 1'b1;
    bus.write_response = 2'b11;
    chk("mrst cmd_ready_low", 64'(bus.cmd_ready), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    bus.write_response_valid = 1'b0;
    bus.write_response = 2'b00;
    chk("mrst valids", 64'({bus.write_address_valid, bus.write_data_valid, status_valid}), 64'(0));
    chk("mrst error_count", 64'(error_count), 64'(0));
    chk("mrst timeout", 64'(status_timeout), 64'(0));
    chk("mrst state", 64'(state_dbg), 64'(0));
    @(negedge aclk);
    chk("mrst no_status", 64'(status_valid), 64'(0));
    v = '{32'h0000_0040, 32'h4444_4444, 4'hF, 1, 0, 0, 2'b00, 16'd0, 1'b0};
    run_vec(v, "after_rst");

    // Saturation: preload the counter just below the top, then push past it.
    force dut.error_count_q = 16'hFFFE;
    @(negedge aclk);
    release dut.error_count_q;
    @(negedge aclk);
    chk("sat preload", 64'(error_count), 64'(16'hFFFE));
    v = '{32'h0000_0050, 32'h5555_5555, 4'hF, 0, 0, 0, 2'b10, 16'hFFFF, 1'b0};
    run_vec(v, "sat1");
    run_vec(v, "sat2");
    v = '{32'h0000_0054, 32'h6666_6666, 4'hF, 0, 0, 0, 2'b00, 16'hFFFF, 1'b0};
    run_vec(v, "sat_okay");

    chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
